motion_detect_core: RTL
=======================

// Module: motion_detect_core
// PURPOSE
//  Parametrised background-subtraction motion detector. Consumes a raster grey-level pixel stream, keeps a per-pixel
//  background in external SRAM (read-modify-write, 2 clk/pixel), emits a binary motion mask and per-frame object stats
//  (count, bounding box, quartile centre). Sits between the camera/SDRAM frame reader and the VGA/tracking logic.
// PARAMETERS
//  DATA_W     16        pixel/background width (unsigned)
//  ADDR_W     20        SRAM word address width
//  IMG_W      640       pixels per line;  IMG_H  480  lines per frame
//  BG_BASE    20'h00000 SRAM word address of background pixel (0,0); pixel n at BG_BASE+n
//  DIFF_THR   24        |in-bg| >= DIFF_THR marks motion
//  MARGIN     20        columns x<MARGIN or x>IMG_W-1-MARGIN never marked
//  STEP_THR   4         |in-bg| > STEP_THR selects STEP_BIG else STEP_SMALL
//  STEP_BIG   4 ; STEP_SMALL 2   background adaptation steps
//  MIN_COUNT  16        obj_valid requires count >= MIN_COUNT
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        async active-low reset
//  mode        in   2        0 ADAPT, 1 FREEZE (no SRAM writes), 2 RELEARN (bg:=in), 3 reserved=ADAPT
//  pix_valid   in   1        pixel available
//  pix_ready   out  1        pixel accepted when valid&ready
//  pix_sof     in   1        qualifies first pixel of a frame
//  pix_data    in   DATA_W   grey pixel
//  sram_addr   out  ADDR_W   SRAM address
//  sram_wdata  out  DATA_W   write data (tristate at top level)
//  sram_we_n   out  1        write strobe, active low
//  sram_rdata  in   DATA_W   asynchronous read data
//  mask_valid  out  1        one-cycle strobe per processed pixel
//  mask_data   out  1        1 = motion
//  frame_done  out  1        one-cycle pulse after last pixel of a frame
//  obj_valid   out  1        last frame count >= MIN_COUNT
//  obj_count   out  20       motion pixels, last frame
//  bbox_x0/x1  out  10       min/max motion x; bbox_y0/y1 out 10 min/max motion y
//  ctr_x/ctr_y out  10       (q1+q3)>>1 of coordinates at motion pixel #prev_count/4 and #3*prev_count/4
// BEHAVIOUR
//  Reset: all outputs 0, pix_ready 0 for one cycle then 1, sram_we_n 1, state S_READ, x=y=0, first_frame=1.
//  FSM S_READ: pix_ready=1; sram_addr=BG_BASE+y*IMG_W+x; on accept latch pix_data, sram_rdata -> S_WRITE.
//   S_WRITE: pix_ready=0; compute diff/update; sram_we_n=0 unless FREEZE; sram_addr same; -> S_READ.
//  Throughput 1 pixel / 2 clk; mask_valid/mask_data registered, asserted the cycle after S_WRITE.
//  Update (ADAPT): in>bg: bg+step clamped to in; in<bg: bg-step clamped to in; equal: bg. No wrap.
//  RELEARN or first_frame: write bg:=in; mask forced 0; stats accumulate nothing.
//  Diff computed in DATA_W+1 bits, unsigned magnitude; mask=(diff>=DIFF_THR)&&x in margin window.
//  mode sampled only at frame start (x=y=0 accept); mid-frame changes ignored until next frame.
//  Counters: x wraps at IMG_W-1 to 0 with y++; after (IMG_W-1,IMG_H-1): frame_done=1 next cycle, stats
//   latched to outputs, prev_count:=count, running count/bbox reset, first_frame:=0.
//  pix_sof accepted at (x,y)!=(0,0): partial frame discarded, no frame_done, counters restart at pixel 0.
//  pix_sof absent at (0,0): accepted, no error. Stall (pix_valid=0) holds S_READ, no SRAM write.
//  count==0: obj_valid=0, bbox/ctr outputs 0. prev_count<4: quartile points taken at motion pixel #0.
//  count saturates at 2^20-1.
//  obj_* outputs hold until next frame_done.
// STRUCTURE
//  Package md_pkg: md_mode_e (ADAPT,FREEZE,RELEARN), md_state_e (S_READ,S_WRITE), COORD_W=10, CNT_W=20.
//  Sub-module md_bg_update: combinational diff/step/clamp, ports bg,in,mode -> new_bg,diff,is_motion_raw.
// TESTING
//  1 Reset, first frame const 100 -> SRAM all 100, mask all 0, frame_done after 2*IMG_W*IMG_H+1 clk, obj_valid 0.
//  2 Bg 100, frame with 8x8 block of 200 at (300,200) -> obj_count 64, bbox 300..307/200..207, obj_valid 1.
//  3 Bg 100, input 103 ADAPT -> written 102 (clamp no, step 2); input 101 -> 101 (clamped); input 90 -> 96.
//  4 FREEZE, block as in 2 for 3 frames -> sram_we_n stays 1, count 64 every frame; RELEARN -> bg:=in, mask 0.
//  5 Block at x=5 (inside MARGIN) diff 150 -> mask 0, obj_count 0, bbox 0.
//  6 pix_sof at pixel 1000 mid-frame, and rst_n low mid-frame -> no frame_done, stats unchanged/zeroed, restart.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and widths for the background-subtraction motion detector.
package md_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CNT_W   = 20;

  typedef enum logic [1:0] {
    ADAPT   = 2'd0,
    FREEZE  = 2'd1,
    RELEARN = 2'd2
  } md_mode_e;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } md_state_e;

  // Reserved encoding 3 behaves as ADAPT.
  function automatic md_mode_e decode_mode(input logic [1:0] m);
    md_mode_e r;
    unique case (m)
      2'd1:    r = FREEZE;
      2'd2:    r = RELEARN;
      default: r = ADAPT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_bg_update.sv
// Combinational per-pixel difference, motion threshold and background step/clamp.
module md_bg_update import md_pkg::*; #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DIFF_THR   = 24,
  parameter int unsigned STEP_THR   = 4,
  parameter int unsigned STEP_BIG   = 4,
  parameter int unsigned STEP_SMALL = 2
) (
  input  logic [DATA_W-1:0] bg_i,
  input  logic [DATA_W-1:0] in_i,
  input  md_mode_e          mode_i,
  output logic [DATA_W-1:0] new_bg_o,
  output logic [DATA_W-1:0] diff_o,
  output logic              is_motion_raw_o
);

  logic [DATA_W:0]   sub_ib, sub_bi;
  logic              in_gt, in_lt;
  logic [DATA_W-1:0] step;

  always_comb begin
    sub_ib = {1'b0, in_i} - {1'b0, bg_i};
    sub_bi = {1'b0, bg_i} - {1'b0, in_i};
    in_gt  = in_i > bg_i;
    in_lt  = in_i < bg_i;
    diff_o = in_gt ? sub_ib[DATA_W-1:0] : sub_bi[DATA_W-1:0];
    step   = (diff_o > DATA_W'(STEP_THR)) ? DATA_W'(STEP_BIG) : DATA_W'(STEP_SMALL);
    is_motion_raw_o = diff_o >= DATA_W'(DIFF_THR);

    new_bg_o = bg_i;
    unique case (mode_i)
      RELEARN: new_bg_o = in_i;
      FREEZE:  new_bg_o = bg_i;
      default: begin
        // A step that would overshoot the input lands exactly on it, so no wrap is possible.
        if (in_gt)      new_bg_o = (diff_o > step) ? bg_i + step : in_i;
        else if (in_lt) new_bg_o = (diff_o > step) ? bg_i - step : in_i;
      end
    endcase
  end

endmodule

// File: rtl/motion_detect_core.sv
// Raster motion detector: 2-clock SRAM read-modify-write per pixel, motion mask and frame stats.
module motion_detect_core import md_pkg::*; #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 20,
  parameter int unsigned       IMG_W      = 640,
  parameter int unsigned       IMG_H      = 480,
  parameter logic [ADDR_W-1:0] BG_BASE    = '0,
  parameter int unsigned       DIFF_THR   = 24,
  parameter int unsigned       MARGIN     = 20,
  parameter int unsigned       STEP_THR   = 4,
  parameter int unsigned       STEP_BIG   = 4,
  parameter int unsigned       STEP_SMALL = 2,
  parameter int unsigned       MIN_COUNT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic               pix_sof_i,
  input  logic [DATA_W-1:0]  pix_data_i,
  output logic [ADDR_W-1:0]  sram_addr_o,
  output logic [DATA_W-1:0]  sram_wdata_o,
  output logic               sram_we_n_o,
  input  logic [DATA_W-1:0]  sram_rdata_i,
  output logic               mask_valid_o,
  output logic               mask_data_o,
  output logic               frame_done_o,
  output logic               obj_valid_o,
  output logic [CNT_W-1:0]   obj_count_o,
  output logic [COORD_W-1:0] bbox_x0_o,
  output logic [COORD_W-1:0] bbox_x1_o,
  output logic [COORD_W-1:0] bbox_y0_o,
  output logic [COORD_W-1:0] bbox_y1_o,
  output logic [COORD_W-1:0] ctr_x_o,
  output logic [COORD_W-1:0] ctr_y_o
);

  localparam logic [COORD_W-1:0] XLast  = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] YLast  = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] XLo    = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] XHi    = COORD_W'(IMG_W - 1 - MARGIN);
  localparam logic [CNT_W-1:0]   CntMax = '1;

  md_state_e         state_q;
  md_mode_e          mode_q, mode_new, upd_mode;
  logic              pix_ready_q, we_n_q, first_frame_q;
  logic              mask_valid_q, mask_data_q, frame_done_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] pix_q, bg_q, new_bg, diff_unused;
  logic              motion_raw, accept, restart, frame_start, mask, last_pix;

  logic [CNT_W-1:0]   cnt_q, cnt_d, prev_q, q1_idx, q3_idx;
  logic [COORD_W-1:0] bx0_q, bx1_q, by0_q, by1_q, bx0_d, bx1_d, by0_d, by1_d;
  logic [COORD_W-1:0] q1x_q, q1y_q, q3x_q, q3y_q, q1x_d, q1y_d, q3x_d, q3y_d;

  logic               obj_valid_q;
  logic [CNT_W-1:0]   obj_count_q;
  logic [COORD_W-1:0] ox0_q, ox1_q, oy0_q, oy1_q, ocx_q, ocy_q;

  md_bg_update #(
    .DATA_W    (DATA_W),
    .DIFF_THR  (DIFF_THR),
    .STEP_THR  (STEP_THR),
    .STEP_BIG  (STEP_BIG),
    .STEP_SMALL(STEP_SMALL)
  ) u_bg_update (
    .bg_i           (bg_q),
    .in_i           (pix_q),
    .mode_i         (upd_mode),
    .new_bg_o       (new_bg),
    .diff_o         (diff_unused),
    .is_motion_raw_o(motion_raw)
  );

  // pix_ready_q is only ever high in S_READ.
  assign accept      = pix_ready_q & pix_valid_i;
  assign restart     = pix_valid_i & pix_sof_i;
  assign frame_start = restart | (x_q == '0 && y_q == '0);
  assign mode_new    = frame_start ? decode_mode(mode_i) : mode_q;
  assign upd_mode    = first_frame_q ? RELEARN : mode_q;
  assign mask        = motion_raw & (upd_mode != RELEARN) & (x_q >= XLo) & (x_q <= XHi);
  assign last_pix    = (x_q == XLast) && (y_q == YLast);
  // A SOF pixel is pixel 0 of the new frame, so its background read must come from the base.
  assign sram_addr_o = (state_q == S_READ && restart) ? BG_BASE : addr_q;

  always_comb begin
    cnt_d = cnt_q;
    bx0_d = bx0_q; bx1_d = bx1_q; by0_d = by0_q; by1_d = by1_q;
    q1x_d = q1x_q; q1y_d = q1y_q; q3x_d = q3x_q; q3y_d = q3y_q;
    q1_idx = prev_q >> 2;
    q3_idx = (prev_q < CNT_W'(4)) ? '0 :
             CNT_W'(({2'b00, prev_q} + {1'b0, prev_q, 1'b0}) >> 2);
    if (state_q == S_WRITE && mask) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      if (cnt_q == '0) begin
        bx0_d = x_q; bx1_d = x_q; by0_d = y_q; by1_d = y_q;
      end else begin
        if (x_q < bx0_q) bx0_d = x_q;
        if (x_q > bx1_q) bx1_d = x_q;
        if (y_q < by0_q) by0_d = y_q;
        if (y_q > by1_q) by1_d = y_q;
      end
      if (cnt_q == q1_idx) begin q1x_d = x_q; q1y_d = y_q; end
      if (cnt_q == q3_idx) begin q3x_d = x_q; q3y_d = y_q; end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_READ;  mode_q <= ADAPT;  first_frame_q <= 1'b1;
      pix_ready_q <= 1'b0;  we_n_q <= 1'b1;
      mask_valid_q <= 1'b0;  mask_data_q <= 1'b0;  frame_done_q <= 1'b0;
      x_q <= '0;  y_q <= '0;  addr_q <= BG_BASE;  pix_q <= '0;  bg_q <= '0;
      cnt_q <= '0;  prev_q <= '0;
      bx0_q <= '0; bx1_q <= '0; by0_q <= '0; by1_q <= '0;
      q1x_q <= '0; q1y_q <= '0; q3x_q <= '0; q3y_q <= '0;
      obj_valid_q <= 1'b0;  obj_count_q <= '0;
      ox0_q <= '0; ox1_q <= '0; oy0_q <= '0; oy1_q <= '0; ocx_q <= '0; ocy_q <= '0;
    end else begin
      mask_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        S_READ: begin
          pix_ready_q <= ~accept;
          if (accept) begin
            state_q <= S_WRITE;
            pix_q   <= pix_data_i;
            bg_q    <= sram_rdata_i;
            mode_q  <= mode_new;
            we_n_q  <= (mode_new == FREEZE) && !first_frame_q;
            if (restart) begin
              x_q <= '0;  y_q <= '0;  addr_q <= BG_BASE;  cnt_q <= '0;
              q1x_q <= '0; q1y_q <= '0; q3x_q <= '0; q3y_q <= '0;
            end
          end
        end
        S_WRITE: begin
          state_q <= S_READ;  pix_ready_q <= 1'b1;  we_n_q <= 1'b1;
          mask_valid_q <= 1'b1;  mask_data_q <= mask;
          cnt_q <= cnt_d;
          bx0_q <= bx0_d; bx1_q <= bx1_d; by0_q <= by0_d; by1_q <= by1_d;
          q1x_q <= q1x_d; q1y_q <= q1y_d; q3x_q <= q3x_d; q3y_q <= q3y_d;
          if (last_pix) begin
            x_q <= '0;  y_q <= '0;  addr_q <= BG_BASE;
            frame_done_q <= 1'b1;  first_frame_q <= 1'b0;  prev_q <= cnt_d;
            obj_count_q <= cnt_d;
            obj_valid_q <= (cnt_d != '0) && (cnt_d >= CNT_W'(MIN_COUNT));
            if (cnt_d == '0) begin
              ox0_q <= '0; ox1_q <= '0; oy0_q <= '0; oy1_q <= '0; ocx_q <= '0; ocy_q <= '0;
            end else begin
              ox0_q <= bx0_d; ox1_q <= bx1_d; oy0_q <= by0_d; oy1_q <= by1_d;
              ocx_q <= COORD_W'(({1'b0, q1x_d} + {1'b0, q3x_d}) >> 1);
              ocy_q <= COORD_W'(({1'b0, q1y_d} + {1'b0, q3y_d}) >> 1);
            end
            cnt_q <= '0;
            q1x_q <= '0; q1y_q <= '0; q3x_q <= '0; q3y_q <= '0;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (x_q == XLast) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: state_q <= S_READ;
      endcase
    end
  end

  assign pix_ready_o  = pix_ready_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_wdata_o = new_bg;
  assign mask_valid_o = mask_valid_q;
  assign mask_data_o  = mask_data_q;
  assign frame_done_o = frame_done_q;
  assign obj_valid_o  = obj_valid_q;
  assign obj_count_o  = obj_count_q;
  assign bbox_x0_o    = ox0_q;
  assign bbox_x1_o    = ox1_q;
  assign bbox_y0_o    = oy0_q;
  assign bbox_y1_o    = oy1_q;
  assign ctr_x_o      = ocx_q;
  assign ctr_y_o      = ocy_q;

endmodule
